// File: rtl/fetch_hazard_ctrl.sv
// rtl/fetch_hazard_ctrl.sv - front-end stall/flush sequencing with instruction fetch wait-state FSM
module fetch_hazard_ctrl #(
    parameter int MAX_WAIT = 16,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_hready,
    input  logic             i_hresp,
    input  logic             d_hready,
    input  logic             lw_hazard_d,
    input  logic             branch_taken_d,
    input  logic             clr_cnt,
    output logic [1:0]       i_htrans,
    output logic             pc_en,
    output logic             fd_en,
    output logic             fd_clr,
    output logic             de_clr,
    output logic             fetch_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int WC_W = $clog2(MAX_WAIT) + 1;
    localparam logic [WC_W-1:0]  WC_LAST = WC_W'(MAX_WAIT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_WAIT,
        S_ERROR
    } state_t;

    state_t          state, state_nxt;
    logic [WC_W-1:0] wait_cnt, wait_cnt_nxt;
    logic            stall_inc;
    logic            flush_inc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            wait_cnt <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        i_htrans     = 2'b00;
        pc_en        = 1'b0;
        fd_en        = 1'b0;
        fd_clr       = 1'b1;
        de_clr       = 1'b1;
        fetch_err    = 1'b0;
        stall_inc    = 1'b0;
        flush_inc    = 1'b0;
        case (state)
            S_IDLE: begin
                state_nxt = S_RUN;
            end
            S_RUN, S_WAIT: begin
                i_htrans = 2'b10;
                fd_clr   = 1'b0;
                de_clr   = 1'b0;
                // Any bus wait freezes the whole pipe; the held branch is taken on release.
                if (!i_hready || !d_hready) begin
                    pc_en = 1'b0;
                end else if (lw_hazard_d) begin
                    de_clr = 1'b1;
                end else if (branch_taken_d) begin
                    pc_en     = 1'b1;
                    fd_en     = 1'b1;
                    fd_clr    = 1'b1;
                    flush_inc = 1'b1;
                end else begin
                    pc_en = 1'b1;
                    fd_en = 1'b1;
                end
                stall_inc = !pc_en;

                if (i_hresp) begin
                    state_nxt = S_ERROR;
                end else if (state == S_RUN) begin
                    if (!i_hready) begin
                        state_nxt    = S_WAIT;
                        wait_cnt_nxt = WC_W'(1);
                    end
                end else if (i_hready) begin
                    state_nxt = S_RUN;
                end else if (wait_cnt == WC_LAST) begin
                    state_nxt = S_ERROR;
                end else begin
                    wait_cnt_nxt = wait_cnt + 1'b1;
                end
            end
            S_ERROR: begin
                de_clr    = 1'b0;
                fetch_err = 1'b1;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else if (clr_cnt) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall_inc && stall_cnt != CNT_MAX) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
            if (flush_inc && flush_cnt != CNT_MAX) begin
                flush_cnt <= flush_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fetch_hazard_ctrl.sv
// tb/tb_fetch_hazard_ctrl.sv - scoreboard bench for fetch_hazard_ctrl
module tb_fetch_hazard_ctrl;

    localparam int MAX_WAIT = 16;
    localparam int CNT_W    = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             i_hready = 1'b1;
    logic             i_hresp = 1'b0;
    logic             d_hready = 1'b1;
    logic             lw_hazard_d = 1'b0;
    logic             branch_taken_d = 1'b0;
    logic             clr_cnt = 1'b0;
    logic [1:0]       i_htrans;
    logic             pc_en;
    logic             fd_en;
    logic             fd_clr;
    logic             de_clr;
    logic             fetch_err;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    fetch_hazard_ctrl #(.MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_hready       (i_hready),
        .i_hresp        (i_hresp),
        .d_hready       (d_hready),
        .lw_hazard_d    (lw_hazard_d),
        .branch_taken_d (branch_taken_d),
        .clr_cnt        (clr_cnt),
        .i_htrans       (i_htrans),
        .pc_en          (pc_en),
        .fd_en          (fd_en),
        .fd_clr         (fd_clr),
        .de_clr         (de_clr),
        .fetch_err      (fetch_err),
        .stall_cnt      (stall_cnt),
        .flush_cnt      (flush_cnt)
    );

    always #5 clk = ~clk;

    // stimulus: {i_hready, i_hresp, d_hready, lw_hazard_d, branch_taken_d, clr_cnt}
    localparam logic [5:0] S_OK     = 6'b101000;
    localparam logic [5:0] S_LW     = 6'b101100;
    localparam logic [5:0] S_BR     = 6'b101010;
    localparam logic [5:0] S_LWBR   = 6'b101110;
    localparam logic [5:0] S_ILO    = 6'b001000;
    localparam logic [5:0] S_ILO_BR = 6'b001010;
    localparam logic [5:0] S_DLO    = 6'b100000;
    localparam logic [5:0] S_HRESP  = 6'b011000;
    localparam logic [5:0] S_CLR    = 6'b000001;

    // expected: {i_htrans[1:0], pc_en, fd_en, fd_clr, de_clr, fetch_err}
    localparam logic [6:0] E_RST = 7'b00_0_0_1_1_0;
    localparam logic [6:0] E_RUN = 7'b10_1_1_0_0_0;
    localparam logic [6:0] E_BUB = 7'b10_0_0_0_1_0;
    localparam logic [6:0] E_FLU = 7'b10_1_1_1_0_0;
    localparam logic [6:0] E_FRZ = 7'b10_0_0_0_0_0;
    localparam logic [6:0] E_ERR = 7'b00_0_0_1_0_1;

    typedef struct {
        int         idx;
        logic [6:0] outs;
        int         sc;
        int         fl;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_bad = 0;
    int   n_push = 0;
    bit   stim_done = 1'b0;

    task automatic cyc(input logic r, input logic [5:0] s, input logic [6:0] e,
                       input int sc, input int fl);
        exp_t x;
        @(posedge clk);
        #1;
        rst_n = r;
        {i_hready, i_hresp, d_hready, lw_hazard_d, branch_taken_d, clr_cnt} = s;
        x.idx  = n_push;
        x.outs = e;
        x.sc   = sc;
        x.fl   = fl;
        q.push_back(x);
        n_push++;
    endtask

    always @(negedge clk) begin
        exp_t x;
        logic [6:0] got;
        if (q.size() > 0) begin
            x   = q.pop_front();
            got = {i_htrans, pc_en, fd_en, fd_clr, de_clr, fetch_err};
            n_vec++;
            if (got !== x.outs || int'(stall_cnt) != x.sc || int'(flush_cnt) != x.fl) begin
                n_bad++;
                $display("FAIL vec%0d outs got %b exp %b, stall_cnt got %0d exp %0d, flush_cnt got %0d exp %0d",
                         x.idx, got, x.outs, stall_cnt, x.sc, flush_cnt, x.fl);
            end
        end
    end

    initial begin
        repeat (2) @(posedge clk);
        cyc(1'b0, S_OK, E_RST, 0, 0);
        // release: one IDLE cycle, then NONSEQ
        cyc(1'b1, S_OK, E_RST, 0, 0);
        cyc(1'b1, S_OK, E_RUN, 0, 0);
        cyc(1'b1, S_OK, E_RUN, 0, 0);
        // load-use then branch, then both together
        cyc(1'b1, S_LW,   E_BUB, 0, 0);
        cyc(1'b1, S_BR,   E_FLU, 1, 0);
        cyc(1'b1, S_OK,   E_RUN, 1, 1);
        cyc(1'b1, S_LWBR, E_BUB, 1, 1);
        cyc(1'b1, S_OK,   E_RUN, 2, 1);
        // 3-cycle fetch wait with branch held
        cyc(1'b1, S_ILO_BR, E_FRZ, 2, 1);
        cyc(1'b1, S_ILO_BR, E_FRZ, 3, 1);
        cyc(1'b1, S_ILO_BR, E_FRZ, 4, 1);
        cyc(1'b1, S_BR,     E_FLU, 5, 1);
        cyc(1'b1, S_OK,     E_RUN, 5, 2);
        cyc(1'b1, S_DLO,    E_FRZ, 5, 2);
        cyc(1'b1, S_OK,     E_RUN, 6, 2);
        cyc(1'b1, S_OK | S_CLR, E_RUN, 6, 2);
        // 15 low cycles: one short of the timeout
        for (int i = 0; i < 15; i++) cyc(1'b1, S_ILO, E_FRZ, i, 0);
        cyc(1'b1, S_OK, E_RUN, 15, 0);
        cyc(1'b1, S_OK | S_CLR, E_RUN, 15, 0);
        // 20 stall cycles saturate the 4-bit counter
        for (int i = 0; i < 20; i++) cyc(1'b1, S_LW, E_BUB, (i > 15) ? 15 : i, 0);
        cyc(1'b1, S_LW | S_CLR, E_BUB, 15, 0);
        cyc(1'b1, S_OK, E_RUN, 0, 0);
        // 16 low cycles: timeout
        for (int i = 0; i < 16; i++) cyc(1'b1, S_ILO, E_FRZ, i, 0);
        for (int i = 0; i < 3; i++) cyc(1'b1, S_OK, E_ERR, 15, 0);
        cyc(1'b0, S_OK, E_RST, 0, 0);
        cyc(1'b1, S_OK, E_RST, 0, 0);
        cyc(1'b1, S_OK, E_RUN, 0, 0);
        // error response together with wait state
        cyc(1'b1, S_HRESP, E_FRZ, 0, 0);
        cyc(1'b1, S_OK,    E_ERR, 1, 0);
        cyc(1'b1, S_ILO,   E_ERR, 1, 0);
        cyc(1'b0, S_OK,    E_RST, 0, 0);
        cyc(1'b1, S_OK,    E_RST, 0, 0);
        cyc(1'b1, S_OK,    E_RUN, 0, 0);
        // reset asserted mid-WAIT
        cyc(1'b1, S_ILO, E_FRZ, 0, 0);
        cyc(1'b1, S_ILO, E_FRZ, 1, 0);
        cyc(1'b0, S_ILO, E_RST, 0, 0);
        cyc(1'b1, S_OK,  E_RST, 0, 0);
        cyc(1'b1, S_OK,  E_RUN, 0, 0);
        stim_done = 1'b1;
    end

    initial begin
        int budget;
        budget = 2000;
        while ((!stim_done || q.size() > 0) && budget > 0) begin
            @(posedge clk);
            budget--;
        end
        if (budget == 0) begin
            n_bad++;
            $display("FAIL timeout pending %0d exp 0", q.size());
        end
        if (n_vec != n_push) begin
            n_bad++;
            $display("FAIL vec_count got %0d exp %0d", n_vec, n_push);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/fetch_hazard_ctrl.md
# fetch_hazard_ctrl

Front-end pipeline controller for the AHB-attached MIPS core. It drives the PC enable, the fetch/decode register's EN and CLR, and the decode/execute bubble clear. It also drives the instruction-side AHB HTRANS, so that instruction wait states, load-use hazards and taken branches are sequenced consistently. A small FSM tracks fetch wait states with a timeout, and saturating counters record stall and flush activity.

## Interface
- MAX_WAIT, 16: instruction-side wait-state limit before a fetch error is declared
- CNT_W, 16: width of the performance counters
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- i_hready  in  1  instruction-side AHB HREADY
- i_hresp  in  1  instruction-side AHB HRESP (1 = ERROR)
- d_hready  in  1  data-side AHB HREADY (low freezes the whole pipe)
- lw_hazard_d  in  1  load-use hazard detected in decode
- branch_taken_d  in  1  branch/jump resolved taken in decode
- clr_cnt  in  1  synchronous clear of both counters
- i_htrans  out  2  instruction-side HTRANS (00 IDLE, 10 NONSEQ)
- pc_en  out  1  PC register load enable
- fd_en  out  1  fetch/decode register EN
- fd_clr  out  1  fetch/decode register CLR
- de_clr  out  1  decode/execute register CLR (bubble insert)
- fetch_err  out  1  sticky fetch error flag
- stall_cnt  out  CNT_W  cycles with pc_en=0 while in RUN/WAIT, saturating
- flush_cnt  out  CNT_W  branch flushes issued, saturating

## Operation
- FSM states: IDLE, RUN, WAIT, ERROR. Reset enters IDLE.
- IDLE: i_htrans=00; pc_en=fd_en=0; fd_clr=de_clr=1. Next state is unconditionally RUN.
- RUN and WAIT drive i_htrans=10. Outputs follow the priority list below, evaluated combinationally each cycle:
  1. i_hready=0 or d_hready=0: freeze, with pc_en=fd_en=fd_clr=de_clr=0.
  2. lw_hazard_d=1: pc_en=fd_en=0, de_clr=1, fd_clr=0. This takes priority over a concurrent branch.
  3. branch_taken_d=1: pc_en=fd_en=1, fd_clr=1, de_clr=0, and flush_cnt increments.
  4. Otherwise: pc_en=fd_en=1, fd_clr=de_clr=0.
- RUN transitions:
  - i_hresp=1 → ERROR.
  - i_hready=0 → WAIT, with wait_cnt loaded to 1.
  - Otherwise stay in RUN.
- WAIT transitions:
  - i_hresp=1 → ERROR.
  - i_hready=1 → RUN. Outputs in that same cycle follow rules 2–4.
  - i_hready=0 with wait_cnt==MAX_WAIT-1 → ERROR.
  - Otherwise wait_cnt increments.
- ERROR: i_htrans=00; pc_en=fd_en=de_clr=0; fd_clr=1; fetch_err=1. ERROR exits only via rst_n.
- stall_cnt increments in any RUN/WAIT cycle with pc_en=0. flush_cnt increments per rule 3.
- Both counters saturate at 2^CNT_W-1. clr_cnt zeroes them and takes priority over any increment in the same cycle.
- The internal wait_cnt width is ceil(log2(MAX_WAIT))+1 bits.

## Timing
- Control outputs are combinational from state and inputs (zero latency). State and counters update on posedge clk.
- Reset values: state IDLE, wait_cnt 0, stall_cnt 0, flush_cnt 0.
  - i_htrans=00, pc_en=0, fd_en=0, fd_clr=1, de_clr=1, fetch_err=0.
- The first NONSEQ appears in the second cycle after rst_n deasserts.
- A branch flush lasts exactly one cycle. Decode is frozen during a stall, so branch_taken_d is held by the datapath and acted on when the stall releases.
- Load-use produces exactly one bubble per cycle lw_hazard_d is high.
- Simultaneous i_hresp=1 and i_hready=0 → ERROR, not WAIT.
- Reset asserted mid-WAIT or mid-ERROR returns immediately (asynchronously) to IDLE values.
- The timeout triggers on the MAX_WAIT-th consecutive low i_hready cycle.

## Test plan
- Reset release, i_hready=d_hready=1, no hazards:
  - cycle 1 shows fd_clr=de_clr=1 with i_htrans=00;
  - from cycle 2, i_htrans=10 and pc_en=fd_en=1 continuously;
  - stall_cnt stays 0.
- Load-use for 1 cycle followed by a branch: the bubble cycle shows pc_en=fd_en=0 and de_clr=1; the next cycle shows fd_clr=1, pc_en=1 and flush_cnt=1. Also drive lw_hazard_d and branch_taken_d together and check that only de_clr asserts.
- i_hready low for 3 cycles while branch_taken_d is held:
  - 3 freeze cycles with all enables 0 and stall_cnt=3;
  - on the release cycle, fd_clr=1 and pc_en=1.
- i_hready low for 16 cycles with MAX_WAIT=16 → fetch_err=1, i_htrans=00 and fd_clr=1, held until rst_n pulses. Repeat with a low of 15 cycles and check no error.
- i_hresp=1 with i_hready=0 in RUN → ERROR next cycle. Then assert rst_n low mid-ERROR and check all outputs return to reset values asynchronously.
- Preload stall_cnt near 2^CNT_W-1 (CNT_W=4, 20 stall cycles) and check it saturates at 15. Then assert clr_cnt together with a stall cycle and check 0.
